// File: rtl/data_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : data_axi_bridge
//  Description : Turns the memory stage's single-cycle data request into one
//                single-beat AXI3 read or write and stalls until it completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_axi_bridge #(
    parameter logic [3:0] AXI_ID   = 4'd1,
    parameter int         KSEG_MAP = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [1:0]  size,
    input  logic [31:0] writedata,
    input  logic        advance,
    output logic [31:0] rdata_out,
    output logic        stall_req,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic [3:0]  arid,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic [3:0]  awid,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [3:0]  wid,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_A  = 3'd1;
    localparam logic [2:0] S_RD_D  = 3'd2;
    localparam logic [2:0] S_WR_AW = 3'd3;
    localparam logic [2:0] S_WR_B  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_sel;
    logic [1:0]  r_size;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] w_paddr;
    logic        w_req;
    logic        w_aw_hs;
    logic        w_w_hs;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space
    assign w_paddr = ((KSEG_MAP != 0) && (addr[31:30] == 2'b10)) ? {3'b000, addr[28:0]} : addr;
    assign w_req   = en & (r_state == S_IDLE);
    assign w_aw_hs = awvalid & awready;
    assign w_w_hs  = wvalid & wready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (en) w_next = write ? S_WR_AW : S_RD_A;
            S_RD_A:  if (arready) w_next = S_RD_D;
            S_RD_D:  if (rvalid) w_next = S_DONE;
            S_WR_AW: if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_next = S_WR_B;
            S_WR_B:  if (bvalid) w_next = S_DONE;
            // A flushed request (en low) needs no advance to release the FSM
            S_DONE:  if (advance || !en) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (r_state)
            S_RD_A:  arvalid = 1'b1;
            S_RD_D:  rready  = 1'b1;
            S_WR_AW: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
            end
            S_WR_B:  bready  = 1'b1;
            default: ;
        endcase
    end

    assign stall_req = resetn & en & (r_state != S_DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_sel     <= 4'd0;
            r_size    <= 2'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            if (w_req) begin
                r_addr    <= w_paddr;
                r_wdata   <= writedata;
                r_sel     <= sel;
                r_size    <= size;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if ((r_state == S_RD_D) && rvalid) r_rdata <= rdata;
        end
    end

    assign rdata_out = r_rdata;
    assign araddr    = r_addr;
    assign awaddr    = r_addr;
    assign arsize    = {1'b0, r_size};
    assign awsize    = {1'b0, r_size};
    assign arid      = AXI_ID;
    assign awid      = AXI_ID;
    assign wid       = AXI_ID;
    assign wlast     = 1'b1;
    assign wdata     = r_wdata;
    assign wstrb     = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_data_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_axi_bridge
//  Description : Self-checking bench for data_axi_bridge (vectors + random).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_axi_bridge;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rval;
        int          ard;
        int          rd;
        int          awd;
        int          wdl;
        int          bd;
        int          hold;
        int          flush_at;
        logic [31:0] exp_addr;
        int          exp_cyc;
    } vec_t;

    logic        clk;
    logic        resetn, en, write, advance, arready, rvalid, awready, wready, bvalid;
    logic [31:0] addr, writedata, rdata;
    logic [3:0]  sel;
    logic [1:0]  size;
    logic [31:0] rdata_out, araddr, awaddr, wdata;
    logic        stall_req, arvalid, rready, awvalid, wvalid, wlast, bready;
    logic [2:0]  arsize, awsize;
    logic [3:0]  arid, awid, wid, wstrb;

    logic        k_en, k_arready, k_rvalid;
    logic [31:0] k_addr, k_rdata;
    logic [31:0] k_rdata_out, k_araddr, k_awaddr, k_wdata;
    logic        k_stall_req, k_arvalid, k_rready, k_awvalid, k_wvalid, k_wlast, k_bready;
    logic [2:0]  k_arsize, k_awsize;
    logic [3:0]  k_arid, k_awid, k_wid, k_wstrb;

    int          n_checks;
    int          n_errors;
    logic [31:0] last_rdata;
    vec_t        vec [8];
    vec_t        rv;

    data_axi_bridge #(.AXI_ID(4'd1), .KSEG_MAP(1)) u_dut (
        .clk(clk), .resetn(resetn), .en(en), .write(write), .addr(addr), .sel(sel),
        .size(size), .writedata(writedata), .advance(advance), .rdata_out(rdata_out),
        .stall_req(stall_req), .araddr(araddr), .arsize(arsize), .arid(arid),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid),
        .rready(rready), .awaddr(awaddr), .awsize(awsize), .awid(awid),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wid(wid),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    data_axi_bridge #(.AXI_ID(4'd1), .KSEG_MAP(0)) u_dut_flat (
        .clk(clk), .resetn(resetn), .en(k_en), .write(1'b0), .addr(k_addr), .sel(4'h0),
        .size(2'd2), .writedata(32'h0), .advance(1'b0), .rdata_out(k_rdata_out),
        .stall_req(k_stall_req), .araddr(k_araddr), .arsize(k_arsize), .arid(k_arid),
        .arvalid(k_arvalid), .arready(k_arready), .rdata(k_rdata), .rvalid(k_rvalid),
        .rready(k_rready), .awaddr(k_awaddr), .awsize(k_awsize), .awid(k_awid),
        .awvalid(k_awvalid), .awready(1'b0), .wdata(k_wdata), .wstrb(k_wstrb), .wid(k_wid),
        .wlast(k_wlast), .wvalid(k_wvalid), .wready(1'b0), .bvalid(1'b0), .bready(k_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic clear_slave();
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    // One request acting as a slave with per-channel response delays
    task automatic do_txn(input vec_t v);
        int  stalls, exp_st, n_ar, n_r, n_aw, n_w, ar_w, r_w, aw_w, w_w, b_w;
        bit  done;
        @(negedge clk);
        en = 1'b1; write = v.write; addr = v.addr; sel = v.sel; size = v.size;
        writedata = v.wdata; advance = 1'b0;
        clear_slave();
        #1;
        chk1("req_stall", stall_req, 1'b1);
        stalls = 1;
        n_ar = 0; n_r = 0; n_aw = 0; n_w = 0;
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
        done = 1'b0;
        for (int c = 1; c < 200 && !done; c++) begin
            @(negedge clk);
            clear_slave();
            if (v.flush_at != 0 && c >= v.flush_at) en = 1'b0;
            #1;
            if (stall_req) stalls++;
            if (v.flush_at != 0 && c >= v.flush_at) chk1("flush_stall", stall_req, 1'b0);
            if (arvalid) begin
                arready = (ar_w >= v.ard); ar_w++;
                if (arready) begin
                    n_ar++;
                    chk("araddr", araddr, v.exp_addr);
                    chk("arsize", {29'b0, arsize}, {30'b0, v.size});
                end
            end
            if (rready) begin
                rvalid = (r_w >= v.rd); r_w++;
                rdata  = rvalid ? v.rval : $urandom;
                if (rvalid) begin n_r++; done = 1'b1; end
            end
            if (awvalid) begin
                awready = (aw_w >= v.awd); aw_w++;
                if (awready) begin
                    n_aw++;
                    chk("awaddr", awaddr, v.exp_addr);
                    chk("awsize", {29'b0, awsize}, {30'b0, v.size});
                end
            end
            if (wvalid) begin
                wready = (w_w >= v.wdl); w_w++;
                if (wready) begin
                    n_w++;
                    chk("wdata", wdata, v.wdata);
                    chk("wstrb", {28'b0, wstrb}, {28'b0, v.sel});
                    chk1("wlast", wlast, 1'b1);
                end
            end
            if (bready) begin
                if (b_w == 0) chk1("bready_order", (n_aw == 1 && n_w == 1), 1'b1);
                bvalid = (b_w >= v.bd); b_w++;
                if (bvalid) done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL txn_timeout: got no response, expected one within 200 cycles");
        end
        exp_st = v.exp_cyc;
        if (v.flush_at != 0 && v.flush_at < exp_st) exp_st = v.flush_at;
        chk("stall_cycles", stalls, exp_st);
        chk("ar_handshakes", n_ar, v.write ? 0 : 1);
        chk("aw_handshakes", n_aw, v.write ? 1 : 0);
        chk("w_handshakes", n_w, v.write ? 1 : 0);
        if (!v.write) last_rdata = v.rval;
        @(negedge clk);
        clear_slave();
        #1;
        chk1("done_stall", stall_req, 1'b0);
        chk("rdata_out", rdata_out, last_rdata);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            #1;
            chk1("hold_stall", stall_req, 1'b0);
            chk1("hold_reissue", arvalid | awvalid, 1'b0);
        end
        if (v.flush_at == 0) advance = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; last_rdata = 32'h0;
        resetn = 1'b0; en = 1'b0; write = 1'b0; addr = 32'h0; sel = 4'h0; size = 2'd0;
        writedata = 32'h0; advance = 1'b0; rdata = 32'h0;
        clear_slave();
        k_en = 1'b0; k_addr = 32'h0; k_arready = 1'b0; k_rvalid = 1'b0; k_rdata = 32'h0;

        //            wr    addr          sel    sz    wdata         rval         ard rd awd wdl bd hold flush exp_addr     cyc
        vec[0] = '{1'b0, 32'h8000_1000, 4'h0, 2'd2, 32'h0000_0000, 32'hDEAD_BEEF, 2, 3, 0, 0, 0, 4, 0, 32'h0000_1000, 8};
        vec[1] = '{1'b1, 32'hA000_0003, 4'h8, 2'd0, 32'h5A5A_5A5A, 32'h0000_0000, 0, 0, 2, 0, 1, 0, 0, 32'h0000_0003, 6};
        vec[2] = '{1'b0, 32'h9FC0_0000, 4'h0, 2'd2, 32'h0000_0000, 32'h0123_4567, 0, 0, 0, 0, 0, 0, 0, 32'h1FC0_0000, 3};
        vec[3] = '{1'b1, 32'h9000_0002, 4'hC, 2'd1, 32'hBEEF_BEEF, 32'h0000_0000, 0, 0, 0, 3, 0, 1, 0, 32'h1000_0002, 6};
        vec[4] = '{1'b0, 32'hC000_0010, 4'h0, 2'd1, 32'h0000_0000, 32'hCAFE_F00D, 1, 0, 0, 0, 0, 0, 0, 32'hC000_0010, 4};
        vec[5] = '{1'b1, 32'h0000_0040, 4'hF, 2'd2, 32'h1122_3344, 32'h0000_0000, 0, 0, 1, 1, 2, 0, 0, 32'h0000_0040, 6};
        vec[6] = '{1'b0, 32'h7FFF_FFFC, 4'h0, 2'd0, 32'h0000_0000, 32'h55AA_00FF, 0, 2, 0, 0, 0, 2, 0, 32'h7FFF_FFFC, 5};
        vec[7] = '{1'b0, 32'h8000_2000, 4'h0, 2'd2, 32'h0000_0000, 32'hFACE_0001, 2, 1, 0, 0, 0, 0, 2, 32'h0000_2000, 6};

        repeat (2) @(negedge clk);
        #1;
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid", wvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_bready", bready, 1'b0);
        chk1("rst_stall", stall_req, 1'b0);
        chk("rst_rdata_out", rdata_out, 32'h0);
        chk1("rst_wlast", wlast, 1'b1);
        chk("rst_ids", {20'b0, arid, awid, wid}, 32'h0000_0111);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) do_txn(vec[i]);

        // Reset while waiting for read data: response must be dropped
        @(negedge clk);
        en = 1'b1; write = 1'b0; addr = 32'h8000_0100; size = 2'd2; advance = 1'b0;
        clear_slave();
        @(negedge clk); #1;
        chk1("mr_arvalid", arvalid, 1'b1);
        arready = 1'b1;
        @(negedge clk); arready = 1'b0; #1;
        chk1("mr_rready_pre", rready, 1'b1);
        resetn = 1'b0; en = 1'b0;
        @(negedge clk); #1;
        chk1("mr_rready", rready, 1'b0);
        chk1("mr_arvalid_rst", arvalid, 1'b0);
        chk1("mr_stall", stall_req, 1'b0);
        chk("mr_rdata_out", rdata_out, 32'h0);
        resetn = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678;
        @(negedge clk); rvalid = 1'b0; #1;
        chk("mr_discard", rdata_out, 32'h0);
        chk1("mr_idle_rready", rready, 1'b0);
        last_rdata = 32'h0;

        for (int i = 0; i < 40; i++) begin
            rv.write = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            rv.sel   = 4'($urandom);
            rv.size  = 2'($urandom_range(0, 2));
            rv.wdata = $urandom;
            rv.rval  = $urandom;
            rv.ard   = $urandom_range(0, 3);
            rv.rd    = $urandom_range(0, 3);
            rv.awd   = $urandom_range(0, 3);
            rv.wdl   = $urandom_range(0, 3);
            rv.bd    = $urandom_range(0, 3);
            rv.exp_addr = (rv.addr[31:30] == 2'b10) ? (rv.addr & 32'h1FFF_FFFF) : rv.addr;
            rv.exp_cyc  = rv.write ? 3 + ((rv.awd > rv.wdl) ? rv.awd : rv.wdl) + rv.bd
                                   : 3 + rv.ard + rv.rd;
            rv.flush_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, rv.exp_cyc - 1) : 0;
            rv.hold     = (rv.flush_at != 0) ? 0 : $urandom_range(0, 2);
            do_txn(rv);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                en = 1'b0; advance = 1'b0;
                #1;
                chk1("gap_stall", stall_req, 1'b0);
            end
        end

        @(negedge clk);
        en = 1'b0; advance = 1'b0;
        k_en = 1'b1; k_addr = 32'h9FC0_0000;
        @(negedge clk); #1;
        chk1("flat_arvalid", k_arvalid, 1'b1);
        chk("flat_araddr", k_araddr, 32'h9FC0_0000);
        k_arready = 1'b1;
        @(negedge clk); k_arready = 1'b0; #1;
        chk1("flat_rready", k_rready, 1'b1);
        k_rvalid = 1'b1; k_rdata = 32'h0BAD_CAFE;
        @(negedge clk); k_rvalid = 1'b0; #1;
        chk("flat_rdata_out", k_rdata_out, 32'h0BAD_CAFE);
        chk1("flat_done_stall", k_stall_req, 1'b0);
        k_en = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_axi_bridge.md
Name: data_axi_bridge

Overview:
- Converts the memory stage's single-cycle data request into single-beat AXI3 read/write transactions.
- Holds the pipeline with a stall request until the response returns.
- Sits between the memory stage's data-port outputs (en, write, addr, sel, size, writedata) and the SoC AXI interconnect.
- Returns the raw aligned 32-bit read word to the memory stage, which performs byte/half extraction.

Parameters:
AXI_ID, 4'd1, constant ID driven on arid/awid/wid
KSEG_MAP, 1, 1 = strip addr[31:29] to 3'b000 when addr[31:30]==2'b10 (kseg0/kseg1); 0 = pass-through

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
en  in  1  data request valid (already gated by exception)
write  in  1  1 = store, 0 = load
addr  in  32  virtual byte address
sel  in  4  byte strobes for store
size  in  2  0 = byte, 1 = half, 2 = word
writedata  in  32  store data, lane-replicated
advance  in  1  pipeline register in front of mem stage updates this cycle
rdata_out  out  32  read word to mem stage
stall_req  out  1  hold pipeline
araddr  out  32  AXI read address
arsize  out  3  {1'b0,size}
arid  out  4  AXI_ID
arvalid  out  1
arready  in  1
rdata  in  32
rvalid  in  1
rready  out  1
awaddr  out  32
awsize  out  3
awid  out  4  AXI_ID
awvalid  out  1
awready  in  1
wdata  out  32
wstrb  out  4
wid  out  4  AXI_ID
wlast  out  1  constant 1
wvalid  out  1
wready  in  1
bvalid  in  1
bready  out  1

Behaviour:
- Reset: state IDLE; arvalid, awvalid, wvalid, rready, bready = 0; rdata_out = 0; stall_req = 0.
- Reset asserted mid-transaction aborts to IDLE the same cycle; outstanding AXI responses are discarded.
- Burst fields: arlen/awlen = 0, burst INCR, single beat. rresp/bresp are ignored.
- Address translation: when KSEG_MAP = 1 and addr[31:30] == 2'b10, the physical address is {3'b000, addr[28:0]}. Otherwise the address passes through unchanged.
- Address, size, sel and writedata are captured into registers on the request cycle and held until the handshake completes.
- State IDLE:
  - en = 1 and write = 0 → RD_A: arvalid = 1 next cycle.
  - en = 1 and write = 1 → WR_AW: awvalid = 1 and wvalid = 1 next cycle.
- State RD_A: hold arvalid until arready; on handshake → RD_D, with rready = 1.
- State RD_D: on rvalid, latch rdata into rdata_out and go to DONE.
- State WR_AW:
  - awvalid and wvalid drop independently after their own handshakes; per-channel done flags track this.
  - Simultaneous handshakes in one cycle count for both channels.
  - When both channels are done → WR_B, with bready = 1.
- State WR_B: on bvalid → DONE.
- State DONE: stall_req = 0. Stay in DONE until advance = 1, then go to IDLE. This prevents re-issue while another stall source freezes the mem stage.
- stall_req = en & (state != DONE). This is combinational, so it asserts in the request cycle itself.
- Minimum load latency, measured from first en cycle to stall_req low:
  - load: 3 cycles (arready and rvalid each returned one cycle after presentation);
  - store: 3 cycles (awready/wready and bvalid returned the same way).
- rdata_out holds its value until the next read completes. Stores do not change it.
- en dropping while not in IDLE (e.g. the request is flushed) does not abort the AXI transaction. The transaction completes, stall_req goes low because en = 0, and the FSM returns to IDLE. From DONE it returns to IDLE with no wait for advance.
- Back-to-back requests: a new en in the cycle after DONE→IDLE starts a new transaction.

Test Plan:
- Load word: en = 1, write = 0, addr = 32'h8000_1000, size = 2. Slave gives arready after 2 cycles and rvalid with 32'hDEAD_BEEF after 3 more cycles. Required: araddr = 32'h0000_1000, arsize = 3'b010, stall_req high until the DONE cycle, rdata_out = 32'hDEAD_BEEF.
- Store byte: addr = 32'hA000_0003, sel = 4'b1000, writedata = 32'h5A5A_5A5A. Slave gives wready 2 cycles before awready. Required: wvalid drops first, awvalid holds until its handshake, wstrb = 4'b1000, awaddr = 32'h0000_0003, bready asserted only after both handshakes.
- Held pipeline: after DONE, keep en = 1 and advance = 0 for 4 cycles. Required: no second arvalid, stall_req = 0 throughout. Asserting advance = 1 returns the FSM to IDLE.
- Reset mid-read: assert resetn = 0 during RD_D. Required: next cycle rready = 0, arvalid = 0, stall_req = 0, rdata_out = 0.
- Flush during transaction: drop en in RD_A. Required: the AR handshake and R response still complete, stall_req = 0 from the cycle en drops, no new request is issued.
- KSEG_MAP = 0: addr = 32'h9FC0_0000. Required: araddr = 32'h9FC0_0000.
